// File: rtl/bifrost_irq_pkg.sv
// bifrost_irq_pkg: register offsets, VECTOR layout and the priority encoder
// shared by the BIFROST interrupt controller.
package bifrost_irq_pkg;

    // Register offsets inside the interrupt controller window
    localparam logic [2:0] IRQ_RAW     = 3'd0;
    localparam logic [2:0] IRQ_PENDING = 3'd1;
    localparam logic [2:0] IRQ_ENABLE  = 3'd2;
    localparam logic [2:0] IRQ_MODE    = 3'd3;
    localparam logic [2:0] IRQ_VECTOR  = 3'd4;
    localparam logic [2:0] IRQ_FORCE   = 3'd5;

    // VECTOR register layout: {any, 4'b0, idx[2:0]}
    localparam int VEC_ANY_BIT = 7;
    localparam int VEC_IDX_MSB = 2;
    localparam int VEC_IDX_LSB = 0;

    // Lowest set bit wins (bit 0 = highest priority); 0 when nothing is set
    function automatic logic [2:0] irq_prio_idx(input logic [7:0] req);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Build the VECTOR read value from the masked pending set
    function automatic logic [7:0] irq_vector(input logic [7:0] masked);
        logic [7:0] v;
        v = 8'h00;
        v[VEC_ANY_BIT] = |masked;
        v[VEC_IDX_MSB:VEC_IDX_LSB] = irq_prio_idx(masked);
        return v;
    endfunction

endpackage

// File: rtl/bifrost_irq_sync.sv
// bifrost_irq_sync: WIDTH-bit wide, STAGES-deep synchroniser for the
// asynchronous interrupt sources. Clears to 0 (inactive) on reset.
module bifrost_irq_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // Shift the sampled sources down the flop chain each clock
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/bifrost_irq.sv
// bifrost_irq: parametrised interrupt controller. Up to 8 active-low
// sources are synchronised, latched (edge) or followed (level), masked,
// and combined into one active-low IRQB for the 6502.
//
// Register access: a write commits only on the clock where reg_strobe is
// high with reg_cs_n low and reg_rw low (reg_strobe acts as valid, the
// block is always ready, so every qualified strobe is accepted). Reads are
// combinational from reg_addr and have no side effects.
module bifrost_irq
    import bifrost_irq_pkg::*;
#(
    parameter int         CHANNELS     = 8,
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] RESET_ENABLE = 8'h00
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                reg_cs_n,
    input  logic                reg_rw,
    input  logic                reg_strobe,
    input  logic [2:0]          reg_addr,
    input  logic [7:0]          reg_wdata,
    output logic [7:0]          reg_rdata,
    input  logic [CHANNELS-1:0] irq_in_n,
    output logic                irq_out_n,
    output logic [7:0]          irq_leds
);

    logic [CHANNELS-1:0] act;
    logic [CHANNELS-1:0] prev;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] pending_next;
    logic [CHANNELS-1:0] enable;
    logic [CHANNELS-1:0] mode;
    logic [CHANNELS-1:0] wd;
    logic [CHANNELS-1:0] w1c;
    logic [CHANNELS-1:0] force_set;
    logic [CHANNELS-1:0] mode_arm;
    logic                wr_commit;
    logic [7:0]          raw8;
    logic [7:0]          pend8;
    logic [7:0]          en8;
    logic [7:0]          mode8;

    // Sources are active-low on the pins; the chain carries active-high
    bifrost_irq_sync #(
        .WIDTH  (CHANNELS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .din   (~irq_in_n),
        .dout  (act)
    );

    assign wr_commit = reg_strobe & ~reg_cs_n & ~reg_rw;
    assign wd        = reg_wdata[CHANNELS-1:0];

    // Per-register write strobes, already restricted to implemented channels
    always_comb begin
        w1c       = '0;
        force_set = '0;
        mode_arm  = '0;
        if (wr_commit && reg_addr == IRQ_PENDING) begin
            w1c = wd;
        end
        if (wr_commit && reg_addr == IRQ_FORCE) begin
            force_set = wd;
        end
        if (wr_commit && reg_addr == IRQ_MODE) begin
            mode_arm = wd & ~mode;
        end
    end

    // Track the synced level one clock late for rising-edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= act;
        end
    end

    // ENABLE and MODE are plain read/write registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable <= RESET_ENABLE[CHANNELS-1:0];
            mode   <= '0;
        end else if (wr_commit) begin
            if (reg_addr == IRQ_ENABLE) begin
                enable <= wd;
            end
            if (reg_addr == IRQ_MODE) begin
                mode <= wd;
            end
        end
    end

    // Next PENDING: switching a channel to edge clears it; level channels
    // follow act; edge channels latch a rising edge or FORCE, and a new set
    // beats a W1C in the same clock
    always_comb begin
        pending_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (mode_arm[i]) begin
                pending_next[i] = 1'b0;
            end else if (!mode[i]) begin
                pending_next[i] = act[i];
            end else begin
                pending_next[i] = (act[i] & ~prev[i]) | force_set[i]
                                | (pending[i] & ~w1c[i]);
            end
        end
    end

    // Latch the pending set
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Zero-extend per-channel state to the 8-bit register view
    always_comb begin
        raw8  = 8'h00;
        pend8 = 8'h00;
        en8   = 8'h00;
        mode8 = 8'h00;
        for (int i = 0; i < CHANNELS; i++) begin
            raw8[i]  = act[i];
            pend8[i] = pending[i];
            en8[i]   = enable[i];
            mode8[i] = mode[i];
        end
    end

    // Register read mux; FORCE and unused offsets read 0
    always_comb begin
        reg_rdata = 8'h00;
        case (reg_addr)
            IRQ_RAW:     reg_rdata = raw8;
            IRQ_PENDING: reg_rdata = pend8;
            IRQ_ENABLE:  reg_rdata = en8;
            IRQ_MODE:    reg_rdata = mode8;
            IRQ_VECTOR:  reg_rdata = irq_vector(pend8 & en8);
            default:     reg_rdata = 8'h00;
        endcase
    end

    // Only flops feed the IRQ output, so it cannot glitch on decode paths
    assign irq_out_n = ~|(pending & enable);
    assign irq_leds  = pend8;

endmodule

// File: tb/tb_bifrost_irq.sv
// tb_bifrost_irq: directed register-level bench for bifrost_irq. Reads
// push their expected {irq_out_n, rdata} into a queue; a monitor pops and
// compares on the falling edge whenever a read is presented.
module tb_bifrost_irq;

    localparam logic [2:0] A_RAW = 3'd0;
    localparam logic [2:0] A_PEN = 3'd1;
    localparam logic [2:0] A_ENA = 3'd2;
    localparam logic [2:0] A_MOD = 3'd3;
    localparam logic [2:0] A_VEC = 3'd4;
    localparam logic [2:0] A_FRC = 3'd5;

    logic       clock;
    logic       reset;
    logic       reg_cs_n;
    logic       reg_rw;
    logic       reg_strobe;
    logic [2:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic [7:0] irq_in_n;
    logic       irq_out_n;
    logic [7:0] irq_leds;

    logic       rd_valid;
    logic [8:0] exp_q[$];
    string      name_q[$];
    logic [8:0] exp_item;
    string      exp_name;
    int         checks;
    int         errors;

    bifrost_irq #(
        .CHANNELS     (8),
        .SYNC_STAGES  (2),
        .RESET_ENABLE (8'h00)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .reg_cs_n   (reg_cs_n),
        .reg_rw     (reg_rw),
        .reg_strobe (reg_strobe),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .irq_in_n   (irq_in_n),
        .irq_out_n  (irq_out_n),
        .irq_leds   (irq_leds)
    );

    // Clock and watchdog
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        reg_addr   = a;
        reg_wdata  = d;
        reg_cs_n   = 1'b0;
        reg_rw     = 1'b0;
        reg_strobe = 1'b1;
        tick();
        reg_strobe = 1'b0;
        reg_cs_n   = 1'b1;
        reg_rw     = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] d,
                      input logic irq, input string nm);
        reg_addr = a;
        reg_cs_n = 1'b0;
        reg_rw   = 1'b1;
        rd_valid = 1'b1;
        exp_q.push_back({irq, d});
        name_q.push_back(nm);
        tick();
        rd_valid = 1'b0;
        reg_cs_n = 1'b1;
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: got rdata=%02h irq_out_n=%0b, no expectation queued",
                         reg_rdata, irq_out_n);
            end else begin
                exp_item = exp_q.pop_front();
                exp_name = name_q.pop_front();
                if ({irq_out_n, reg_rdata} !== exp_item) begin
                    errors++;
                    $display("FAIL %s: got rdata=%02h irq_out_n=%0b, expected rdata=%02h irq_out_n=%0b",
                             exp_name, reg_rdata, irq_out_n, exp_item[7:0], exp_item[8]);
                end
                if (reg_addr == A_PEN) begin
                    checks++;
                    if (irq_leds !== exp_item[7:0]) begin
                        errors++;
                        $display("FAIL %s_leds: got irq_leds=%02h, expected %02h",
                                 exp_name, irq_leds, exp_item[7:0]);
                    end
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        reg_cs_n   = 1'b1;
        reg_rw     = 1'b1;
        reg_strobe = 1'b0;
        reg_addr   = 3'd0;
        reg_wdata  = 8'h00;
        irq_in_n   = 8'hFF;
        rd_valid   = 1'b0;
        idle(3);
        reset = 1'b0;
        tick();

        // Reset values
        rd(A_RAW, 8'h00, 1'b1, "rst_raw");
        rd(A_PEN, 8'h00, 1'b1, "rst_pending");
        rd(A_ENA, 8'h00, 1'b1, "rst_enable");
        rd(A_MOD, 8'h00, 1'b1, "rst_mode");
        rd(A_VEC, 8'h00, 1'b1, "rst_vector");
        rd(A_FRC, 8'h00, 1'b1, "rst_force");

        // Level channel 0: assert latency and release latency
        wr(A_ENA, 8'h01);
        irq_in_n[0] = 1'b0;
        rd(A_RAW, 8'h00, 1'b1, "lvl_lat0");
        rd(A_RAW, 8'h00, 1'b1, "lvl_lat1");
        rd(A_RAW, 8'h01, 1'b1, "lvl_lat2");
        rd(A_RAW, 8'h01, 1'b0, "lvl_lat3");
        rd(A_VEC, 8'h80, 1'b0, "lvl_vector");
        irq_in_n[0] = 1'b1;
        rd(A_RAW, 8'h01, 1'b0, "lvl_rel0");
        rd(A_RAW, 8'h01, 1'b0, "lvl_rel1");
        rd(A_RAW, 8'h00, 1'b0, "lvl_rel2");
        rd(A_RAW, 8'h00, 1'b1, "lvl_rel3");

        // Edge channel 2: latch, hold after release, W1C
        wr(A_MOD, 8'h04);
        wr(A_ENA, 8'h04);
        irq_in_n[2] = 1'b0;
        idle(5);
        irq_in_n[2] = 1'b1;
        idle(4);
        rd(A_PEN, 8'h04, 1'b0, "edge_pending");
        rd(A_VEC, 8'h82, 1'b0, "edge_vector");
        rd(A_RAW, 8'h00, 1'b0, "edge_raw_released");
        wr(A_PEN, 8'h04);
        rd(A_PEN, 8'h00, 1'b1, "edge_w1c");
        // Held active: one latch only
        irq_in_n[2] = 1'b0;
        idle(5);
        rd(A_PEN, 8'h04, 1'b0, "edge_held_latch");
        wr(A_PEN, 8'h04);
        idle(3);
        rd(A_PEN, 8'h00, 1'b1, "edge_held_once");
        irq_in_n[2] = 1'b1;
        idle(4);
        rd(A_PEN, 8'h00, 1'b1, "edge_held_release");

        // Priority between edge channels 1 and 5
        wr(A_MOD, 8'h26);
        wr(A_ENA, 8'hFF);
        irq_in_n[1] = 1'b0;
        irq_in_n[5] = 1'b0;
        idle(3);
        irq_in_n[1] = 1'b1;
        irq_in_n[5] = 1'b1;
        idle(4);
        rd(A_VEC, 8'h81, 1'b0, "prio_vec_1");
        rd(A_PEN, 8'h22, 1'b0, "prio_pending");
        wr(A_PEN, 8'h02);
        rd(A_VEC, 8'h85, 1'b0, "prio_vec_5");
        wr(A_PEN, 8'h20);
        rd(A_VEC, 8'h00, 1'b1, "prio_vec_none");

        // FORCE and W1C/edge collision on channel 3
        wr(A_MOD, 8'h2E);
        wr(A_FRC, 8'h08);
        rd(A_PEN, 8'h08, 1'b0, "force_set");
        rd(A_FRC, 8'h00, 1'b0, "force_reads0");
        irq_in_n[3] = 1'b0;
        tick();
        tick();
        wr(A_PEN, 8'h08);
        rd(A_PEN, 8'h08, 1'b0, "collision_set_wins");
        irq_in_n[3] = 1'b1;
        idle(4);
        wr(A_PEN, 8'h08);
        rd(A_PEN, 8'h00, 1'b1, "collision_cleared");
        wr(A_FRC, 8'h01);
        rd(A_PEN, 8'h00, 1'b1, "force_level_ignored");
        rd(3'd6, 8'h00, 1'b1, "unused6");
        wr(3'd7, 8'h00);
        rd(A_ENA, 8'hFF, 1'b1, "unused7_write");

        // Masking keeps PENDING
        wr(A_MOD, 8'h3E);
        wr(A_FRC, 8'h10);
        rd(A_PEN, 8'h10, 1'b0, "mask_pending");
        wr(A_ENA, 8'h00);
        rd(A_PEN, 8'h10, 1'b1, "mask_keeps");
        rd(A_VEC, 8'h00, 1'b1, "mask_vector");

        // Asynchronous reset in the middle of a pulse
        irq_in_n[4] = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        rd(A_PEN, 8'h00, 1'b1, "rst_async_pending");
        rd(A_MOD, 8'h00, 1'b1, "rst_async_mode");
        irq_in_n = 8'hFF;
        tick();
        reset = 1'b0;
        idle(4);
        rd(A_RAW, 8'h00, 1'b1, "post_rst_raw");
        rd(A_PEN, 8'h00, 1'b1, "post_rst_pending");
        rd(A_ENA, 8'h00, 1'b1, "post_rst_enable");
        rd(A_MOD, 8'h00, 1'b1, "post_rst_mode");
        rd(A_VEC, 8'h00, 1'b1, "post_rst_vector");

        // Every queued expectation must have been consumed
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d leftover entries, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
